// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Central stall/flush scheduler for a 5-stage pipeline. Three causes are
// arbitrated in priority order: a multi-cycle data-memory access, a load-use
// dependency and a taken branch. The block also owns the data-memory
// request/acknowledge handshake, detects memory timeouts and counts the
// cycles in which the PC is held.
//
// Handshake: DMEM_REQ follows MEM_ACCESS while the controller is healthy.
// An access completes in any cycle where DMEM_REQ=1 and DMEM_ACK=1.
// DMEM_ACK with no request pending is ignored. If MEM_ACCESS drops while
// waiting, the access is treated as complete.
//
// Ports:
//   CLOCK, RESET             clock, synchronous active-high reset
//   ID_RS, ID_RT             source register fields of the instruction in ID
//   ID_USES_RS, ID_USES_RT   the ID instruction reads rs / rt
//   EXE_MEMREAD, EXE_DEST    the EXE instruction is a load, and its destination
//   BRANCH_TAKEN             branch/jump resolved taken in ID
//   MEM_ACCESS, DMEM_ACK     MEM-stage access request, and memory completion
//   DMEM_REQ                 request to data memory
//   PC_STALL, STALL_*/FLUSH_* hold / bubble controls per pipeline register
//   MEM_TIMEOUT              sticky timeout error flag
//   STALL_CYCLES             saturating count of cycles with PC_STALL=1
//   dbg_state                current FSM state (0 RUN, 1 MEM_WAIT, 2 ERROR)
// -----------------------------------------------------------------------------
module pipeline_hazard_controller #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [4:0]       ID_RS,
  input  logic [4:0]       ID_RT,
  input  logic             ID_USES_RS,
  input  logic             ID_USES_RT,
  input  logic             EXE_MEMREAD,
  input  logic [4:0]       EXE_DEST,
  input  logic             BRANCH_TAKEN,
  input  logic             MEM_ACCESS,
  input  logic             DMEM_ACK,
  output logic             DMEM_REQ,
  output logic             PC_STALL,
  output logic             STALL_IFID,
  output logic             FLUSH_IFID,
  output logic             STALL_IDEXE,
  output logic             FLUSH_IDEXE,
  output logic             STALL_EXEMEM,
  output logic             FLUSH_EXEMEM,
  output logic             STALL_MEMWB,
  output logic             FLUSH_MEMWB,
  output logic             MEM_TIMEOUT,
  output logic [CNT_W-1:0] STALL_CYCLES,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  // Last wait-counter value allowed before giving up on the access.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state;
  state_t      state_next;
  logic [15:0] wait_cnt;
  logic        mem_hold;
  logic        luh;

  // Memory stall: an access is outstanding and not completing this cycle.
  assign mem_hold = (state != ST_ERROR) && MEM_ACCESS && !DMEM_ACK;

  // Load-use: the EXE load writes a register the ID instruction reads.
  // r0 is never a real dependency.
  assign luh = EXE_MEMREAD && (EXE_DEST != 5'd0) &&
               ((ID_USES_RS && (ID_RS == EXE_DEST)) ||
                (ID_USES_RT && (ID_RT == EXE_DEST)));

  assign dbg_state   = state;
  assign MEM_TIMEOUT = (state == ST_ERROR);

  // State register, wait counter and stall-cycle counter.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state        <= ST_RUN;
      wait_cnt     <= 16'd0;
      STALL_CYCLES <= '0;
    end else begin
      state <= state_next;
      // Counter only runs while waiting; it is zero on every entry to MEM_WAIT.
      if (state == ST_MEM_WAIT) begin
        wait_cnt <= wait_cnt + 16'd1;
      end else begin
        wait_cnt <= 16'd0;
      end
      if (PC_STALL && (STALL_CYCLES != {CNT_W{1'b1}})) begin
        STALL_CYCLES <= STALL_CYCLES + CNT_ONE;
      end
    end
  end

  // Next-state logic. An ack in the deadline cycle wins over the timeout
  // because mem_hold is already low in that cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (mem_hold) state_next = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (!mem_hold) begin
          state_next = ST_RUN;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next = ST_ERROR;
        end
      end
      ST_ERROR: state_next = ST_ERROR;
      default:  state_next = ST_RUN;
    endcase
  end

  // Output logic. Priority: reset > error > memory stall > load-use > branch.
  always_comb begin
    DMEM_REQ     = 1'b0;
    PC_STALL     = 1'b0;
    STALL_IFID   = 1'b0;
    FLUSH_IFID   = 1'b0;
    STALL_IDEXE  = 1'b0;
    FLUSH_IDEXE  = 1'b0;
    STALL_EXEMEM = 1'b0;
    FLUSH_EXEMEM = 1'b0;
    STALL_MEMWB  = 1'b0;
    FLUSH_MEMWB  = 1'b0;
    if (RESET) begin
      PC_STALL     = 1'b1;
      FLUSH_IFID   = 1'b1;
      FLUSH_IDEXE  = 1'b1;
      FLUSH_EXEMEM = 1'b1;
      FLUSH_MEMWB  = 1'b1;
    end else if (state == ST_ERROR) begin
      // Freeze the front of the pipeline and keep bubbling MEM/WB.
      PC_STALL     = 1'b1;
      STALL_IFID   = 1'b1;
      STALL_IDEXE  = 1'b1;
      STALL_EXEMEM = 1'b1;
      FLUSH_MEMWB  = 1'b1;
    end else begin
      DMEM_REQ = MEM_ACCESS;
      if (mem_hold) begin
        PC_STALL     = 1'b1;
        STALL_IFID   = 1'b1;
        STALL_IDEXE  = 1'b1;
        STALL_EXEMEM = 1'b1;
        FLUSH_MEMWB  = 1'b1;
      end else if (luh) begin
        // One bubble: the load reaches MEM next cycle and can be forwarded.
        PC_STALL    = 1'b1;
        STALL_IFID  = 1'b1;
        FLUSH_IDEXE = 1'b1;
      end else if (BRANCH_TAKEN) begin
        FLUSH_IFID = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// Directed testbench for pipeline_hazard_controller.
// u_a: TIMEOUT=4, CNT_W=16 (functional and timeout checks).
// u_b: TIMEOUT=1000, CNT_W=4 (counter saturation check).
// Both instances share the same inputs.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_controller;

  // Output pattern bit order:
  // {DMEM_REQ, PC_STALL, STALL_IFID, FLUSH_IFID, STALL_IDEXE, FLUSH_IDEXE,
  //  STALL_EXEMEM, FLUSH_EXEMEM, STALL_MEMWB, FLUSH_MEMWB}
  localparam logic [9:0] P_RESET   = 10'b0101010101;
  localparam logic [9:0] P_IDLE    = 10'b0000000000;
  localparam logic [9:0] P_LUH     = 10'b0110010000;
  localparam logic [9:0] P_LUH_REQ = 10'b1110010000;
  localparam logic [9:0] P_BR      = 10'b0001000000;
  localparam logic [9:0] P_HIT     = 10'b1000000000;
  localparam logic [9:0] P_MEM     = 10'b1110101001;
  localparam logic [9:0] P_ERR     = 10'b0110101001;

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs, id_rt, exe_dest;
  logic       id_uses_rs, id_uses_rt, exe_memread, branch_taken;
  logic       mem_access, dmem_ack;

  logic        a_req, a_pc, a_s_ifid, a_f_ifid, a_s_idexe, a_f_idexe;
  logic        a_s_exemem, a_f_exemem, a_s_memwb, a_f_memwb, a_timeout;
  logic [15:0] a_cycles;
  logic [1:0]  a_state;

  logic        b_req, b_pc, b_s_ifid, b_f_ifid, b_s_idexe, b_f_idexe;
  logic        b_s_exemem, b_f_exemem, b_s_memwb, b_f_memwb, b_timeout;
  logic [3:0]  b_cycles;
  logic [1:0]  b_state;

  wire [9:0] pat_a = {a_req, a_pc, a_s_ifid, a_f_ifid, a_s_idexe, a_f_idexe,
                      a_s_exemem, a_f_exemem, a_s_memwb, a_f_memwb};
  wire [9:0] pat_b = {b_req, b_pc, b_s_ifid, b_f_ifid, b_s_idexe, b_f_idexe,
                      b_s_exemem, b_f_exemem, b_s_memwb, b_f_memwb};

  pipeline_hazard_controller #(.TIMEOUT(4), .CNT_W(16)) u_a (
    .CLOCK(clk), .RESET(rst),
    .ID_RS(id_rs), .ID_RT(id_rt), .ID_USES_RS(id_uses_rs), .ID_USES_RT(id_uses_rt),
    .EXE_MEMREAD(exe_memread), .EXE_DEST(exe_dest), .BRANCH_TAKEN(branch_taken),
    .MEM_ACCESS(mem_access), .DMEM_ACK(dmem_ack),
    .DMEM_REQ(a_req), .PC_STALL(a_pc),
    .STALL_IFID(a_s_ifid), .FLUSH_IFID(a_f_ifid),
    .STALL_IDEXE(a_s_idexe), .FLUSH_IDEXE(a_f_idexe),
    .STALL_EXEMEM(a_s_exemem), .FLUSH_EXEMEM(a_f_exemem),
    .STALL_MEMWB(a_s_memwb), .FLUSH_MEMWB(a_f_memwb),
    .MEM_TIMEOUT(a_timeout), .STALL_CYCLES(a_cycles), .dbg_state(a_state)
  );

  pipeline_hazard_controller #(.TIMEOUT(1000), .CNT_W(4)) u_b (
    .CLOCK(clk), .RESET(rst),
    .ID_RS(id_rs), .ID_RT(id_rt), .ID_USES_RS(id_uses_rs), .ID_USES_RT(id_uses_rt),
    .EXE_MEMREAD(exe_memread), .EXE_DEST(exe_dest), .BRANCH_TAKEN(branch_taken),
    .MEM_ACCESS(mem_access), .DMEM_ACK(dmem_ack),
    .DMEM_REQ(b_req), .PC_STALL(b_pc),
    .STALL_IFID(b_s_ifid), .FLUSH_IFID(b_f_ifid),
    .STALL_IDEXE(b_s_idexe), .FLUSH_IDEXE(b_f_idexe),
    .STALL_EXEMEM(b_s_exemem), .FLUSH_EXEMEM(b_f_exemem),
    .STALL_MEMWB(b_s_memwb), .FLUSH_MEMWB(b_f_memwb),
    .MEM_TIMEOUT(b_timeout), .STALL_CYCLES(b_cycles), .dbg_state(b_state)
  );

  // ---------------- counters ----------------
  int n_asserts = 0;
  int n_fail    = 0;
  int exp_cyc   = 0;

  // ---------------- driver tasks ----------------
  // Advance to just after the next rising edge; inputs are then driven and
  // outputs sampled mid-cycle, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    exe_memread = 1'b0; exe_dest = 5'd0; branch_taken = 1'b0;
    mem_access = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic set_luh(input logic [4:0] dest);
    exe_memread = 1'b1; exe_dest = dest; id_rs = dest; id_uses_rs = 1'b1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    settle();
    check("reset_pattern", 32'(pat_a), 32'(P_RESET));
    check("reset_state", 32'(a_state), 32'(S_RUN));
    check("reset_cycles", 32'(a_cycles), 32'd0);
    check("reset_timeout", 32'(a_timeout), 32'd0);
    tick();
    rst = 1'b0;
    settle();
    check("idle_pattern", 32'(pat_a), 32'(P_IDLE));

    // Load-use on rs
    set_luh(5'd8);
    settle();
    check("luh_rs_pattern", 32'(pat_a), 32'(P_LUH));
    tick(); exp_cyc++;
    clear_inputs();
    settle();
    check("luh_one_cycle", 32'(pat_a), 32'(P_IDLE));
    check("luh_cycles", 32'(a_cycles), 32'(exp_cyc));

    // Destination r0 never stalls
    set_luh(5'd0);
    settle();
    check("luh_r0_pattern", 32'(pat_a), 32'(P_IDLE));
    tick();
    check("luh_r0_cycles", 32'(a_cycles), 32'(exp_cyc));

    // Load-use on rt
    clear_inputs();
    exe_memread = 1'b1; exe_dest = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1;
    settle();
    check("luh_rt_pattern", 32'(pat_a), 32'(P_LUH));
    tick(); exp_cyc++;

    // Matching rs that the instruction does not read
    clear_inputs();
    exe_memread = 1'b1; exe_dest = 5'd5; id_rs = 5'd5;
    settle();
    check("luh_unused_rs", 32'(pat_a), 32'(P_IDLE));

    // Not a load
    exe_memread = 1'b0; id_uses_rs = 1'b1;
    settle();
    check("luh_not_load", 32'(pat_a), 32'(P_IDLE));
    tick();

    // Branch alone, then branch masked by load-use
    clear_inputs();
    branch_taken = 1'b1;
    settle();
    check("branch_pattern", 32'(pat_a), 32'(P_BR));
    tick();
    set_luh(5'd3);
    settle();
    check("branch_luh_pattern", 32'(pat_a), 32'(P_LUH));
    tick(); exp_cyc++;
    check("branch_luh_cycles", 32'(a_cycles), 32'(exp_cyc));

    // Memory hit
    clear_inputs();
    mem_access = 1'b1; dmem_ack = 1'b1;
    settle();
    check("hit_pattern", 32'(pat_a), 32'(P_HIT));
    tick();
    check("hit_state", 32'(a_state), 32'(S_RUN));
    check("hit_cycles", 32'(a_cycles), 32'(exp_cyc));

    // Three-cycle miss
    dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("miss_pattern", 32'(pat_a), 32'(P_MEM));
      tick(); exp_cyc++;
      check("miss_state", 32'(a_state), 32'(S_WAIT));
    end
    dmem_ack = 1'b1;
    settle();
    check("miss_ack_pattern", 32'(pat_a), 32'(P_HIT));
    tick();
    check("miss_done_state", 32'(a_state), 32'(S_RUN));
    check("miss_cycles", 32'(a_cycles), 32'(exp_cyc));

    // Overlap: miss with load-use and branch pending
    clear_inputs();
    mem_access = 1'b1; set_luh(5'd8); branch_taken = 1'b1;
    settle();
    check("overlap_run", 32'(pat_a), 32'(P_MEM));
    tick(); exp_cyc++;
    settle();
    check("overlap_wait", 32'(pat_a), 32'(P_MEM));
    tick(); exp_cyc++;
    dmem_ack = 1'b1;
    settle();
    check("overlap_ack_luh", 32'(pat_a), 32'(P_LUH_REQ));
    tick(); exp_cyc++;
    check("overlap_state", 32'(a_state), 32'(S_RUN));
    clear_inputs();
    settle();
    check("overlap_release", 32'(pat_a), 32'(P_IDLE));
    check("overlap_cycles", 32'(a_cycles), 32'(exp_cyc));

    // MEM_ACCESS dropping during the wait acts as completion
    mem_access = 1'b1;
    tick(); exp_cyc++;
    check("drop_wait_state", 32'(a_state), 32'(S_WAIT));
    mem_access = 1'b0;
    settle();
    check("drop_pattern", 32'(pat_a), 32'(P_IDLE));
    tick();
    check("drop_state", 32'(a_state), 32'(S_RUN));

    // Ack in the deadline cycle wins (TIMEOUT=4: wait counter 3 after 4 edges)
    mem_access = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); exp_cyc++;
    end
    check("deadline_state", 32'(a_state), 32'(S_WAIT));
    dmem_ack = 1'b1;
    settle();
    check("deadline_ack_pattern", 32'(pat_a), 32'(P_HIT));
    tick();
    check("deadline_ack_state", 32'(a_state), 32'(S_RUN));
    check("deadline_no_timeout", 32'(a_timeout), 32'd0);

    // Timeout: four MEM_WAIT cycles without an ack
    dmem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); exp_cyc++;
    end
    check("pre_timeout_flag", 32'(a_timeout), 32'd0);
    tick(); exp_cyc++;
    check("timeout_state", 32'(a_state), 32'(S_ERR));
    check("timeout_flag", 32'(a_timeout), 32'd1);
    settle();
    check("error_pattern", 32'(pat_a), 32'(P_ERR));
    dmem_ack = 1'b1;
    settle();
    check("error_ignores_ack", 32'(pat_a), 32'(P_ERR));
    tick(); exp_cyc++;
    check("error_sticky", 32'(a_state), 32'(S_ERR));
    check("error_cycles", 32'(a_cycles), 32'(exp_cyc));

    // Reset clears the error
    clear_inputs();
    rst = 1'b1;
    settle();
    check("reset_err_pattern", 32'(pat_a), 32'(P_RESET));
    tick();
    rst = 1'b0;
    check("reset_err_timeout", 32'(a_timeout), 32'd0);
    check("reset_err_cycles", 32'(a_cycles), 32'd0);
    check("reset_err_state", 32'(a_state), 32'(S_RUN));
    check("reset_b_cycles", 32'(b_cycles), 32'd0);

    // Saturation on the 4-bit counter
    mem_access = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check("sat_b_14", 32'(b_cycles), 32'd14);
    for (int i = 0; i < 6; i++) tick();
    check("sat_b_15", 32'(b_cycles), 32'd15);
    check("sat_b_state", 32'(b_state), 32'(S_WAIT));
    settle();
    check("sat_b_pattern", 32'(pat_b), 32'(P_MEM));
    check("sat_a_timeout", 32'(a_timeout), 32'd1);

    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("final_b_cycles", 32'(b_cycles), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
